// File: rtl/frame_wr_arbiter.sv
// Round-robin write arbiter into a double-banked frame RAM.
// Banks swap on every rising edge of the 8 kHz frame strobe.
module frame_wr_arbiter #(
   parameter int unsigned NREQ        = 3,
   parameter logic [9:0]  MAX_WAIT    = 10'd200,
   parameter logic [7:0]  FRAME_BYTES = 8'd128
) (
   input  logic              iClk,
   input  logic              reset,
   input  logic              i8KHz,
   input  logic [NREQ-1:0]   iReq,
   input  logic [8*NREQ-1:0] iData,
   input  logic [7*NREQ-1:0] iAddr,
   output logic [NREQ-1:0]   oGnt,
   output logic [7:0]        oData,
   output logic [7:0]        oAddr,
   output logic              oWrEn,
   output logic              oBank,
   output logic [NREQ-1:0]   oStarve,
   output logic              oOvf
);

   localparam int PW = (NREQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            sync1;
   logic            sync2;
   logic            sync3;
   logic            frame_edge;
   logic            wr_bank;
   logic            wr_bank_nxt;
   logic [7:0]      wr_cnt;
   logic [7:0]      wr_cnt_nxt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   rr_ptr_nxt;
   logic [PW-1:0]   sel_idx;
   logic            sel_vld;
   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] sel;
   logic [9:0]      wait_cnt [NREQ];

   always_ff @(posedge iClk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= i8KHz;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign frame_edge = sync2 & ~sync3;

   // A requester holding oGnt still shows its old iReq; keep it out.
   assign cand = iReq & ~oGnt;

   always_comb begin
      int idx;
      idx     = 0;
      sel_vld = 1'b0;
      sel_idx = '0;
      if (state == RUN) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= int'(NREQ)) begin
               idx = idx - int'(NREQ);
            end
            if (!sel_vld && cand[idx[PW-1:0]]) begin
               sel_vld = 1'b1;
               sel_idx = idx[PW-1:0];
            end
         end
      end
   end

   assign sel = sel_vld ? (NREQ'(1) << sel_idx) : '0;

   assign rr_ptr_nxt = !sel_vld ? rr_ptr :
                       (sel_idx == PW'(NREQ - 1)) ? '0 :
                       sel_idx + 1'b1;

   always_comb begin
      state_nxt   = state;
      wr_bank_nxt = wr_bank;
      wr_cnt_nxt  = wr_cnt;
      unique case (state)
         IDLE: begin
            if (frame_edge) begin
               state_nxt   = RUN;
               wr_bank_nxt = 1'b0;
               wr_cnt_nxt  = '0;
            end
         end
         RUN: begin
            // a grant on the frame edge is write 1 of the new frame
            if (frame_edge) begin
               wr_bank_nxt = ~wr_bank;
               wr_cnt_nxt  = {7'd0, sel_vld};
            end else begin
               wr_cnt_nxt  = wr_cnt + {7'd0, sel_vld};
            end
            if (wr_cnt_nxt == FRAME_BYTES) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (frame_edge) begin
               state_nxt   = RUN;
               wr_bank_nxt = ~wr_bank;
               wr_cnt_nxt  = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (reset) begin
         state   <= IDLE;
         wr_bank <= 1'b0;
         wr_cnt  <= '0;
         rr_ptr  <= '0;
         oGnt    <= '0;
         oWrEn   <= 1'b0;
         oData   <= '0;
         oAddr   <= '0;
         oBank   <= 1'b1;
         oOvf    <= 1'b0;
      end else begin
         state   <= state_nxt;
         wr_bank <= wr_bank_nxt;
         wr_cnt  <= wr_cnt_nxt;
         rr_ptr  <= rr_ptr_nxt;
         oGnt    <= sel;
         oWrEn   <= sel_vld;
         oBank   <= ~wr_bank_nxt;
         if (sel_vld) begin
            oData <= iData[int'(sel_idx)*8 +: 8];
            oAddr <= {wr_bank_nxt,
                      iAddr[int'(sel_idx)*7 +: 7]};
         end
         if (state == HOLD && |cand) begin
            oOvf <= 1'b1;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (reset) begin
         for (int n = 0; n < int'(NREQ); n++) begin
            wait_cnt[n] <= '0;
         end
         oStarve <= '0;
      end else begin
         for (int n = 0; n < int'(NREQ); n++) begin
            if (iReq[n] && !oGnt[n] && !sel[n]) begin
               if (wait_cnt[n] < MAX_WAIT) begin
                  wait_cnt[n] <= wait_cnt[n] + 10'd1;
                  if (wait_cnt[n] == MAX_WAIT - 10'd1) begin
                     oStarve[n] <= 1'b1;
                  end
               end
            end else begin
               wait_cnt[n] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_wr_arbiter.sv
// Bench for frame_wr_arbiter: directed scenarios plus a
// randomized run against a frame/quota reference model.
module tb_frame_wr_arbiter;

   localparam int N   = 3;
   localparam int MW  = 4;
   localparam int FB  = 128;

   logic        iClk = 1'b0;
   logic        reset = 1'b0;
   logic        i8KHz = 1'b0;
   logic [2:0]  iReq = '0;
   logic [23:0] iData = '0;
   logic [20:0] iAddr = '0;
   logic [2:0]  oGnt;
   logic [7:0]  oData;
   logic [7:0]  oAddr;
   logic        oWrEn;
   logic        oBank;
   logic [2:0]  oStarve;
   logic        oOvf;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit         h0, h1, h2;
   bit         m_started;
   int         m_used;
   bit         m_bank;
   int         m_rr;
   logic [2:0] m_gnt;
   logic       m_wren;
   logic [7:0] m_data;
   logic [7:0] m_addr;
   logic [2:0] m_starve;
   logic       m_ovf;
   int         m_wait [3];

   always #5 iClk = ~iClk;

   frame_wr_arbiter #(
      .NREQ(3),
      .MAX_WAIT(10'd4),
      .FRAME_BYTES(8'd128)
   ) dut (
      .iClk(iClk),
      .reset(reset),
      .i8KHz(i8KHz),
      .iReq(iReq),
      .iData(iData),
      .iAddr(iAddr),
      .oGnt(oGnt),
      .oData(oData),
      .oAddr(oAddr),
      .oWrEn(oWrEn),
      .oBank(oBank),
      .oStarve(oStarve),
      .oOvf(oOvf)
   );

   task automatic model_step();
      int  sel;
      bit  run;
      bit  fe;
      if (reset) begin
         h0 = 0; h1 = 0; h2 = 0;
         m_started = 0; m_used = 0; m_bank = 0; m_rr = 0;
         m_gnt = '0; m_wren = 0; m_data = '0; m_addr = '0;
         m_starve = '0; m_ovf = 0;
         for (int n = 0; n < N; n++) m_wait[n] = 0;
      end else begin
         fe  = h1 && !h2;
         run = m_started && (m_used < FB);
         sel = -1;
         if (run) begin
            for (int i = 0; i < N; i++) begin
               int k;
               k = (m_rr + i) % N;
               if (sel < 0 && iReq[k] && !m_gnt[k]) sel = k;
            end
         end
         if (m_started && !run && |(iReq & ~m_gnt)) m_ovf = 1;
         for (int n = 0; n < N; n++) begin
            if (iReq[n] && !m_gnt[n] && sel != n) begin
               if (m_wait[n] < MW) begin
                  m_wait[n]++;
                  if (m_wait[n] == MW) m_starve[n] = 1'b1;
               end
            end else begin
               m_wait[n] = 0;
            end
         end
         if (fe) begin
            if (!m_started) begin
               m_started = 1;
               m_bank = 0;
            end else begin
               m_bank = !m_bank;
            end
            m_used = 0;
         end
         m_gnt  = '0;
         m_wren = 0;
         if (sel >= 0) begin
            m_used++;
            m_gnt[sel] = 1'b1;
            m_wren = 1;
            m_data = iData[8*sel +: 8];
            m_addr = {m_bank, iAddr[7*sel +: 7]};
            m_rr = (sel + 1) % N;
         end
         h2 = h1; h1 = h0; h0 = i8KHz;
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1; i8KHz = 0; iReq = '0;
      tick(); tick();
      reset = 0;
   endtask

   task automatic start_frame();
      i8KHz = 1;
      repeat (4) tick();
      i8KHz = 0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1; iReq = 3'b111; iData = 24'hFFFFFF; i8KHz = 1;
      tick(); tick();
      checks++;
      if (oGnt !== 3'b000) begin
         errors++; $display("FAIL reset_gnt got=%b exp=000", oGnt);
      end
      checks++;
      if (oWrEn !== 1'b0) begin
         errors++; $display("FAIL reset_wren got=%b exp=0", oWrEn);
      end
      checks++;
      if (oData !== 8'h00 || oAddr !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got=%h/%h exp=00/00", oData, oAddr);
      end
      checks++;
      if (oBank !== 1'b1) begin
         errors++; $display("FAIL reset_bank got=%b exp=1", oBank);
      end
      checks++;
      if (oStarve !== 3'b000 || oOvf !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b/%b exp=000/0", oStarve, oOvf);
      end
      reset = 0; i8KHz = 0; iReq = '0;
      tick();
   endtask

   task automatic test_idle_ignore();
      int pulses;
      do_reset();
      iReq = 3'b001; iData[7:0] = 8'h5A; iAddr[6:0] = 7'd10;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (oWrEn !== 1'b0 || oGnt !== 3'b000) begin
            errors++;
            $display("FAIL idle_nogrant got=%b/%b exp=0/000", oWrEn, oGnt);
         end
      end
      i8KHz = 1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (oWrEn === 1'b1) begin
            pulses++;
            iReq = '0;
            checks++;
            if (oAddr !== 8'h0A || oData !== 8'h5A || oBank !== 1'b1) begin
               errors++;
               $display("FAIL first_write got=%h/%h/%b exp=0a/5a/1",
                        oAddr, oData, oBank);
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL first_pulses got=%0d exp=1", pulses);
      end
      i8KHz = 0;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp;
      do_reset();
      start_frame();
      iReq = 3'b111; iData = 24'h332211; iAddr = {7'd3, 7'd2, 7'd1};
      for (int i = 0; i < 6; i++) begin
         tick();
         exp = 3'b001 << (i % 3);
         checks++;
         if (oGnt !== exp || oWrEn !== 1'b1) begin
            errors++;
            $display("FAIL rr_order step=%0d got=%b/%b exp=%b/1",
                     i, oGnt, oWrEn, exp);
         end
      end
      iReq = '0;
      tick();
   endtask

   task automatic test_quota();
      int cnt;
      int cyc;
      bit got;
      do_reset();
      start_frame();
      iReq = 3'b111;
      cnt = 0; cyc = 0;
      while (cnt < FB && cyc < 400) begin
         tick();
         cyc++;
         if (oWrEn === 1'b1) cnt++;
      end
      checks++;
      if (cnt != FB) begin
         errors++; $display("FAIL quota_fill got=%0d exp=%0d", cnt, FB);
      end
      iReq = 3'b001; iData[7:0] = 8'hC3; iAddr[6:0] = 7'h33;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (oWrEn !== 1'b0) begin
            errors++; $display("FAIL hold_nogrant got=%b exp=0", oWrEn);
         end
      end
      checks++;
      if (oOvf !== 1'b1) begin
         errors++; $display("FAIL hold_ovf got=%b exp=1", oOvf);
      end
      i8KHz = 1;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (oWrEn === 1'b1 && !got) begin
            got = 1;
            iReq = '0;
            checks++;
            if (oAddr !== 8'hB3 || oData !== 8'hC3 || oBank !== 1'b0) begin
               errors++;
               $display("FAIL resume_write got=%h/%h/%b exp=b3/c3/0",
                        oAddr, oData, oBank);
            end
         end
      end
      checks++;
      if (!got || oOvf !== 1'b1) begin
         errors++;
         $display("FAIL resume_grant got=%b/%b exp=1/1", got, oOvf);
      end
      i8KHz = 0;
   endtask

   task automatic test_collide();
      int cnt;
      do_reset();
      start_frame();
      iReq = 3'b111; iAddr = {7'h7F, 7'h55, 7'h2A};
      tick(); tick();
      i8KHz = 1;
      tick(); tick();
      checks++;
      if (oWrEn !== 1'b1 || oAddr[7] !== 1'b0) begin
         errors++;
         $display("FAIL pre_edge got=%b/%b exp=1/0", oWrEn, oAddr[7]);
      end
      tick();
      checks++;
      if (oWrEn !== 1'b1 || oAddr[7] !== 1'b1 || oBank !== 1'b0) begin
         errors++;
         $display("FAIL collide got=%b/%b/%b exp=1/1/0",
                  oWrEn, oAddr[7], oBank);
      end
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (oWrEn === 1'b1) cnt++;
      end
      checks++;
      if (cnt != FB - 1) begin
         errors++; $display("FAIL collide_quota got=%0d exp=%0d", cnt, FB - 1);
      end
      iReq = '0; i8KHz = 0;
   endtask

   task automatic test_starve();
      int cnt;
      int cyc;
      int since2;
      do_reset();
      start_frame();
      iReq = 3'b111;
      cnt = 0; cyc = 0; since2 = 0;
      while (cnt < FB && cyc < 400) begin
         tick();
         cyc++;
         if (oWrEn === 1'b1) cnt++;
         if (oGnt[2] === 1'b1) since2 = 0;
         else since2++;
         checks++;
         if (since2 > 3 || oStarve !== 3'b000) begin
            errors++;
            $display("FAIL rr_nostarve cyc=%0d got=%0d/%b exp<=3/000",
                     cyc, since2, oStarve);
         end
      end
      iReq = 3'b100;
      tick(); tick();
      checks++;
      if (oStarve !== 3'b000) begin
         errors++; $display("FAIL starve_early got=%b exp=000", oStarve);
      end
      repeat (4) tick();
      checks++;
      if (oStarve !== 3'b100) begin
         errors++; $display("FAIL starve_hold got=%b exp=100", oStarve);
      end
      iReq = '0;
   endtask

   task automatic test_reset_mid();
      bit got;
      do_reset();
      start_frame();
      iReq = 3'b111;
      tick(); tick();
      checks++;
      if (oWrEn !== 1'b1) begin
         errors++; $display("FAIL mid_active got=%b exp=1", oWrEn);
      end
      reset = 1;
      tick();
      reset = 0;
      checks++;
      if ({oGnt, oWrEn, oData, oAddr, oBank, oStarve, oOvf} !==
          {3'b000, 1'b0, 8'h00, 8'h00, 1'b1, 3'b000, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset got=%b/%b/%h/%h/%b/%b/%b",
                  oGnt, oWrEn, oData, oAddr, oBank, oStarve, oOvf);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (oWrEn !== 1'b0) begin
            errors++; $display("FAIL mid_nogrant got=%b exp=0", oWrEn);
         end
      end
      i8KHz = 1;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (oWrEn === 1'b1) got = 1;
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL mid_restart got=0 exp=1");
      end
      iReq = '0; i8KHz = 0;
   endtask

   task automatic test_random();
      logic [24:0] dv;
      logic [24:0] ev;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         i8KHz = ((cyc % 200) < 12);
         reset = (cyc == 500);
         tick();
         dv = {oGnt, oWrEn, oData, oAddr, oBank, oStarve, oOvf};
         ev = {m_gnt, m_wren, m_data, m_addr, !m_bank, m_starve, m_ovf};
         checks++;
         if (dv !== ev) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dv, ev);
         end
         for (int n = 0; n < N; n++) begin
            if (!iReq[n] || m_gnt[n]) begin
               iReq[n] = ($urandom_range(0, 3) != 0);
               iData[8*n +: 8] = 8'($urandom);
               iAddr[7*n +: 7] = 7'($urandom);
            end
         end
      end
      reset = 0; iReq = '0; i8KHz = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_idle_ignore();
      test_round_robin();
      test_quota();
      test_collide();
      test_starve();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
